// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among N_REQ requesters.
// Optional packet lock (same owner re-granted) enabled by UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_lock,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic               uart_start,
  output logic [7:0]         uart_d_out,
  input  logic               uart_done
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_DONE = 2'd1;
  localparam logic [1:0] S_WAIT_REL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    own_q, own_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             start_q, start_d;
  logic [7:0]       dout_q, dout_d;

  logic [IW-1:0]    win;
  logic [IW-1:0]    cand;
  logic             win_vld;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  // search starts one past the last acked owner and wraps
  always_comb begin
    win     = '0;
    cand    = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % N_REQ);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
`ifdef UART_ARB_LOCK_EN
    if (lock_q && req[own_q]) begin
      win     = own_q;
      win_vld = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    start_d = start_q;
    dout_d  = dout_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (win_vld && !uart_done) begin
          state_d    = S_WAIT_DONE;
          own_d      = win;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          start_d    = 1'b1;
          dout_d     = req_data[{win, 3'b000} +: 8];
        end
      end
      (state_q == S_WAIT_DONE): begin
        if (uart_done) begin
          start_d = 1'b0;
          state_d = S_WAIT_REL;
        end
      end
      (state_q == S_WAIT_REL): begin
        if (!uart_done) begin
          ack_d   = gnt_q;
          ptr_d   = own_q;
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UART_ARB_LOCK_EN
  always_comb begin
    lock_d = lock_q;
    if (state_q == S_IDLE && win_vld && !uart_done)
      lock_d = 1'b0;
    else if (state_q == S_WAIT_REL && !uart_done)
      lock_d = req_lock[own_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_l) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      own_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      dout_q  <= dout_d;
    end
  end

  assign gnt        = gnt_q;
  assign ack        = ack_q;
  assign busy       = (state_q != S_IDLE);
  assign uart_start = start_q;
  assign uart_d_out = dout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random stimulus for uart_tx_arbiter,
// checked every cycle against a behavioural model of the handshake.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int M_IDLE = 0;
  localparam int M_XFER = 1;
  localparam int M_REL  = 2;

  logic           clk = 1'b0;
  logic           rst_l = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_lock = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           busy;
  logic           uart_start;
  logic [7:0]     uart_d_out;
  logic           uart_done = 1'b0;

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .req        (req),
    .req_data   (req_data),
    .req_lock   (req_lock),
    .gnt        (gnt),
    .ack        (ack),
    .busy       (busy),
    .uart_start (uart_start),
    .uart_d_out (uart_d_out),
    .uart_done  (uart_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int           m_phase = M_IDLE;
  int           m_ptr   = N - 1;
  int           m_own   = 0;
  bit           m_lock  = 1'b0;
  logic [N-1:0] m_gnt   = '0;
  logic [N-1:0] m_ack   = '0;
  logic         m_start = 1'b0;
  logic [7:0]   m_dout  = 8'h00;

  // uart_tx stand-in and requester control
  bit uart_auto = 1'b1;
  bit uart_rand = 1'b0;
  bit req_auto  = 1'b0;
  int lat_done  = 10;
  int lat_rel   = 2;
  int dn_cnt    = 0;
  int rl_cnt    = 0;

  logic       prev_start = 1'b0;
  logic [7:0] obs_q [$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
`ifdef UART_ARB_LOCK_EN
    if (m_lock && req[m_own]) return m_own;
`endif
    for (int k = 1; k <= N; k++)
      if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    m_ack = '0;
    if (!rst_l) begin
      m_phase = M_IDLE;
      m_start = 1'b0;
      m_dout  = 8'h00;
      m_gnt   = '0;
      m_ptr   = N - 1;
      m_own   = 0;
      m_lock  = 1'b0;
      return;
    end
    case (m_phase)
      M_IDLE: begin
        w = pick();
        if (w >= 0 && !uart_done) begin
          m_gnt   = N'(1) << w;
          m_dout  = req_data[8*w +: 8];
          m_start = 1'b1;
          m_own   = w;
          m_lock  = 1'b0;
          m_phase = M_XFER;
        end
      end
      M_XFER: begin
        if (uart_done) begin
          m_start = 1'b0;
          m_phase = M_REL;
        end
      end
      default: begin
        if (!uart_done) begin
          m_ack   = N'(1) << m_own;
          m_ptr   = m_own;
          m_gnt   = '0;
          m_lock  = req_lock[m_own];
          m_phase = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic compare();
    chk("start", 32'(uart_start), 32'(m_start));
    chk("dout",  32'(uart_d_out), 32'(m_dout));
    chk("gnt",   32'(gnt), 32'(m_gnt));
    chk("ack",   32'(ack), 32'(m_ack));
    chk("busy",  32'(busy), 32'(m_phase != M_IDLE));
    chk("ack_1h", 32'($onehot0(ack)), 32'(1));
    if (uart_start && !prev_start) obs_q.push_back(uart_d_out);
    prev_start = uart_start;
  endtask

  task automatic uart_react();
    if (!uart_auto) return;
    if (!uart_done && !uart_start) begin
      if (uart_rand) lat_done = $urandom_range(1, 12);
      dn_cnt = lat_done;
    end else if (!uart_done) begin
      if (dn_cnt <= 1) uart_done = 1'b1;
      else dn_cnt--;
    end else if (uart_start) begin
      if (uart_rand) lat_rel = $urandom_range(0, 3);
      rl_cnt = lat_rel;
    end else begin
      if (rl_cnt == 0) uart_done = 1'b0;
      else rl_cnt--;
    end
  endtask

  task automatic req_react();
    if (!req_auto) return;
    for (int i = 0; i < N; i++) begin
      if (ack[i]) req[i] = 1'b0;
      else if (req[i] && gnt[i] && $urandom_range(0, 15) == 0)
        req[i] = 1'b0;
      else if (!req[i] && $urandom_range(0, 3) == 0) begin
        req_data[8*i +: 8] = 8'($urandom);
        req[i] = 1'b1;
      end
      req_lock[i] = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    uart_react();
    req_react();
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    repeat (3) cyc();
    rst_l = 1'b1;
  endtask

  task automatic wait_ack(input int budget, output logic [N-1:0] a);
    a = '0;
    for (int c = 0; c < budget; c++) begin
      cyc();
      if (ack != '0) begin
        a = ack;
        break;
      end
    end
    if (a == '0) chk("ack_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    req = '0;
    req_lock = '0;
    for (int c = 0; c < 200; c++) begin
      cyc();
      if (!busy && !uart_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_starts(input int n, input int budget);
    int n2;
    n2 = 0;
    for (int c = 0; c < budget && obs_q.size() < n; c++) begin
      cyc();
      if (ack[2]) n2++;
      if (n2 >= 2) req_lock[2] = 1'b0;
    end
    if (obs_q.size() < n) chk("start_timeout", 32'(obs_q.size()), 32'(n));
  endtask

  initial begin
    logic [N-1:0] a;
    logic [7:0]   e28 [5];
    logic [7:0]   e29 [5];
    bit           saw;

    // reset state
    do_reset();
    chk("rst_start", 32'(uart_start), 32'(0));
    chk("rst_dout",  32'(uart_d_out), 32'(0));
    chk("rst_gnt",   32'(gnt), 32'(0));
    chk("rst_busy",  32'(busy), 32'(0));

    // single byte from requester 0
    req_data[7:0] = 8'h68;
    req = 4'b0001;
    cyc();
    chk("r27_start", 32'(uart_start), 32'(1));
    chk("r27_dout",  32'(uart_d_out), 32'h68);
    chk("r27_gnt",   32'(gnt), 32'b0001);
    wait_ack(60, a);
    chk("r27_ack",  32'(a), 32'b0001);
    chk("r27_busy", 32'(busy), 32'(0));
    req = '0;
    cyc();
    chk("r27_ack1", 32'(ack), 32'(0));
    drain();

    // all four held: round-robin order
    do_reset();
    req_data = {8'h44, 8'h43, 8'h42, 8'h41};
    req = 4'b1111;
    obs_q.delete();
    wait_starts(5, 400);
    e28 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};
    for (int k = 0; k < 5; k++)
      chk("r28_seq", 32'((k < obs_q.size()) ? obs_q[k] : 8'h00), 32'(e28[k]));
    drain();

    // packet lock on requester 2
    do_reset();
    req_data = {8'h00, 8'hC2, 8'h00, 8'hA0};
    req = 4'b0101;
    req_lock = 4'b0100;
    obs_q.delete();
    wait_starts(5, 600);
`ifdef UART_ARB_LOCK_EN
    e29 = '{8'hA0, 8'hC2, 8'hC2, 8'hC2, 8'hA0};
`else
    e29 = '{8'hA0, 8'hC2, 8'hA0, 8'hC2, 8'hA0};
`endif
    for (int k = 0; k < 5; k++)
      chk("r29_seq", 32'((k < obs_q.size()) ? obs_q[k] : 8'h00), 32'(e29[k]));
    drain();

    // uart_done still high out of reset
    uart_auto = 1'b0;
    uart_done = 1'b1;
    req_data = {8'h00, 8'h00, 8'h5A, 8'h00};
    req = 4'b0010;
    do_reset();
    repeat (5) begin
      cyc();
      chk("r30_hold", 32'(uart_start), 32'(0));
    end
    uart_done = 1'b0;
    cyc();
    chk("r30_start", 32'(uart_start), 32'(1));
    chk("r30_gnt",   32'(gnt), 32'b0010);
    uart_auto = 1'b1;
    wait_ack(60, a);
    chk("r30_ack", 32'(a), 32'b0010);
    drain();

    // reset mid-transfer aborts without ack
    do_reset();
    req_data[7:0] = 8'h11;
    req = 4'b0001;
    repeat (3) cyc();
    rst_l = 1'b0;
    req = '0;
    cyc();
    chk("r31_start", 32'(uart_start), 32'(0));
    chk("r31_gnt",   32'(gnt), 32'(0));
    chk("r31_ack",   32'(ack), 32'(0));
    rst_l = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      cyc();
      if (ack != '0) saw = 1'b1;
    end
    chk("r31_noack", 32'(saw), 32'(0));
    drain();

    // owner drops req mid-transfer
    do_reset();
    req_data = {8'hD3, 8'h00, 8'hB1, 8'h00};
    req = 4'b1010;
    cyc();
    chk("r32_gnt1", 32'(gnt), 32'b0010);
    chk("r32_dout1", 32'(uart_d_out), 32'hB1);
    cyc();
    req[1] = 1'b0;
    wait_ack(60, a);
    chk("r32_ack1", 32'(a), 32'b0010);
    saw = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (uart_start) begin
        saw = 1'b1;
        break;
      end
    end
    chk("r32_regrant", 32'(saw), 32'(1));
    chk("r32_gnt3",  32'(gnt), 32'b1000);
    chk("r32_dout3", 32'(uart_d_out), 32'hD3);
    wait_ack(60, a);
    chk("r32_ack3", 32'(a), 32'b1000);
    drain();

    // random traffic
    do_reset();
    uart_rand = 1'b1;
    req_auto  = 1'b1;
    repeat (3000) cyc();
    req_auto = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
